// File: rtl/wb_pkg.sv
// Shared definitions for the write-back data stage: FSM encoding and the
// default constant returned for the constant selector code.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    WRITE = 2'b10
  } wb_state_t;

  localparam logic [31:0] DEF_CONST_VAL = 32'hE300_0000;

endpackage

// File: rtl/wb_src_select.sv
// Combinational NSRC:1 source mux with constant injection; also reports
// whether the selected source is ready and whether the selector is legal.
module wb_src_select #(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 8,
  parameter int SELW      = 3,
  parameter int CONST_SEL = 2,
  parameter logic [WIDTH-1:0] CONST_VAL = '0
) (
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_valid,
  output logic [WIDTH-1:0]      data,
  output logic                  ready,
  output logic                  legal
);

  always_comb begin
    data  = '0;
    ready = 1'b0;
    legal = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) begin
        data  = src_data[i*WIDTH +: WIDTH];
        ready = src_valid[i];
        legal = 1'b1;
      end
    end
    // The constant source never stalls, whatever its valid bit says.
    if (legal && (sel == SELW'(CONST_SEL))) begin
      data  = CONST_VAL;
      ready = 1'b1;
    end
  end

endmodule

// File: rtl/wb_data_stage.sv
// Write-back data stage: picks a source, waits (bounded) for it to become
// valid, then issues a single register-file write with a completion pulse.
module wb_data_stage
  import wb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NSRC      = 8,
  parameter int CONST_SEL = 2,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(DEF_CONST_VAL),
  parameter int TIMEOUT   = 64,
  localparam int SELW     = $clog2(NSRC),
  localparam int CNTW     = $clog2(TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [SELW-1:0]       sel,
  input  logic [4:0]            dst,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_valid,
  output logic                  busy,
  output logic                  wr_en,
  output logic [4:0]            wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  done,
  output logic                  err
);

  wb_state_t        state, state_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  logic [SELW-1:0]  sel_q, sel_n;
  logic [4:0]       dst_q, dst_n;
  logic             wr_en_n, done_n, err_n;
  logic [4:0]       wr_addr_n;
  logic [WIDTH-1:0] wr_data_n;

  logic [SELW-1:0]  mux_sel;
  logic [WIDTH-1:0] mux_data;
  logic             mux_ready, mux_legal;

  // In IDLE the live selector is examined; while waiting, the captured one.
  assign mux_sel = (state == IDLE) ? sel : sel_q;

  wb_src_select #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .SELW     (SELW),
    .CONST_SEL(CONST_SEL),
    .CONST_VAL(CONST_VAL)
  ) u_src_select (
    .sel      (mux_sel),
    .src_data (src_data),
    .src_valid(src_valid),
    .data     (mux_data),
    .ready    (mux_ready),
    .legal    (mux_legal)
  );

  // Outputs are computed one cycle ahead so every port comes from a flop;
  // the WRITE state is therefore the cycle in which wr_en is visible.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sel_n     = sel_q;
    dst_n     = dst_q;
    wr_en_n   = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    case (state)
      IDLE: begin
        if (req) begin
          sel_n = sel;
          dst_n = dst;
          if (!mux_legal) begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end else if (mux_ready) begin
            state_n = WRITE;
            done_n  = 1'b1;
            wr_en_n = (dst != 5'd0);
            if (dst != 5'd0) begin
              wr_addr_n = dst;
              wr_data_n = mux_data;
            end
          end else begin
            state_n = WAIT;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        if (mux_ready) begin
          state_n = WRITE;
          done_n  = 1'b1;
          wr_en_n = (dst_q != 5'd0);
          if (dst_q != 5'd0) begin
            wr_addr_n = dst_q;
            wr_data_n = mux_data;
          end
        end else if (cnt == CNTW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_q   <= '0;
      dst_q   <= '0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sel_q   <= sel_n;
      dst_q   <= dst_n;
      busy    <= (state_n != IDLE);
      wr_en   <= wr_en_n;
      done    <= done_n;
      err     <= err_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

endmodule

// File: doc/wb_data_stage.md
WB_DATA_STAGE -- requirements
Module: wb_data_stage

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits.
REQ-002 Parameter NSRC, default 8, number of selectable sources (2..16); SELW = clog2(NSRC).
REQ-003 Parameter CONST_SEL, default 2, selector code that returns the constant instead of src_data slice.
REQ-004 Parameter CONST_VAL, default 32'hE300_0000, constant driven for CONST_SEL (value 227 in bits [31:24]).
REQ-005 Parameter TIMEOUT, default 64, maximum wait cycles for a source to become valid.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req  input  1  write-back request, sampled only when busy=0.
REQ-009 sel  input  SELW  source selector, sampled with req.
REQ-010 dst  input  5  destination register number, sampled with req.
REQ-011 src_data  input  NSRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
REQ-012 src_valid  input  NSRC  per-source ready flag (e.g. hi/lo low while mult/div busy).
REQ-013 busy  output  1  high from cycle after accepted req until return to IDLE.
REQ-014 wr_en  output  1  one-cycle register-file write strobe.
REQ-015 wr_addr  output  5  register number accompanying wr_en.
REQ-016 wr_data  output  WIDTH  registered write data accompanying wr_en.
REQ-017 done  output  1  one-cycle completion pulse (write, suppressed write, or error).
REQ-018 err  output  1  one-cycle error pulse, coincident with done on illegal sel or timeout.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, WRITE.
REQ-020 IDLE + req: capture sel, dst; if sel>=NSRC -> pulse done+err next cycle, stay IDLE; else if source ready -> capture data, go WRITE; else go WAIT, clear wait counter.
REQ-021 Source ready SHALL mean sel==CONST_SEL, or src_valid[sel]==1; CONST_SEL always ready regardless of src_valid.
REQ-022 WAIT: each cycle src_valid[sel_q]==1 -> capture src_data slice into data register, go WRITE; otherwise increment counter.
REQ-023 WAIT: counter reaching TIMEOUT-1 without valid -> pulse done+err, go IDLE, no write.
REQ-024 WRITE: for one cycle drive wr_en=1 (0 if dst_q==0), wr_addr=dst_q, wr_data=captured data, done=1; next state IDLE.
REQ-025 Latency: ready source at req -> wr_en exactly 1 cycle after the req-sampling edge's cycle (req cycle N, wr_en cycle N+1).
REQ-026 wr_data SHALL reflect data captured at acceptance or WAIT exit; later src_data changes SHALL NOT affect it.
REQ-027 req while busy=1 SHALL be ignored; no queuing.
REQ-028 busy SHALL be 1 in WAIT and WRITE, 0 in IDLE.
REQ-029 wr_en, done, err SHALL be 0 in all cycles not listed above; wr_addr/wr_data hold last value when wr_en=0.
REQ-030 Counter width clog2(TIMEOUT)+1; no wrap-around permitted.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE, busy=0, wr_en=0, done=0, err=0, wr_addr=0, wr_data=0, counter=0.
REQ-032 reset mid-WAIT or mid-WRITE SHALL abort without any wr_en pulse in the following cycle; reset dominates req.

Structure
REQ-033 Shared package wb_pkg SHALL hold FSM state encoding (IDLE=2'b00, WAIT=2'b01, WRITE=2'b10) and default CONST_VAL.
REQ-034 Source selection SHALL be a sub-module wb_src_select (combinational NSRC:1 mux with constant injection), instantiated once.
REQ-035 All outputs SHALL be register-driven; no combinational path from inputs to outputs.

Verification
REQ-036 reset, req=1 sel=5 dst=8 src5=32'h1234_5678 valid=all-ones -> cycle N+1 wr_en=1 wr_addr=8 wr_data=32'h1234_5678 done=1.
REQ-037 req sel=2 src_valid=0 -> wr_data=32'hE300_0000, wr_en next cycle, no wait.
REQ-038 req sel=3 src_valid[3]=0 for 10 cycles then 1, src3=32'hCAFE -> busy 11 cycles, wr_data=32'hCAFE; second req during wait ignored.
REQ-039 req sel=4 src_valid[4] never set, TIMEOUT=64 -> done=err=1 after 64 cycles in WAIT, wr_en never asserted.
REQ-040 req dst=0 sel=6 -> done=1, wr_en=0; NSRC=6 build with sel=7 -> done=err=1 next cycle.
REQ-041 reset asserted while in WAIT with valid rising same cycle -> IDLE, no wr_en, all outputs zero.
